// File: rtl/gpio_rate_counter_if.sv
// Control and status bundle for gpio_rate_counter.
// Controls are sampled on every rising clk edge; status outputs are registered and valid every cycle.
interface gpio_rate_counter_if #(
  parameter int WIDTH  = 20,
  parameter int WRAP_W = 16
);
  logic              en;
  logic              clr;
  logic              load;
  logic [WIDTH-1:0]  load_val;
  logic              dir;
  logic              one_shot;
  logic [WIDTH-1:0]  data;
  logic              tc;
  logic              running;
  logic [WRAP_W-1:0] wrap_cnt;
  logic              dbg_state;

  modport master (
    output en, clr, load, load_val, dir, one_shot,
    input  data, tc, running, wrap_cnt, dbg_state
  );

  modport slave (
    input  en, clr, load, load_val, dir, one_shot,
    output data, tc, running, wrap_cnt, dbg_state
  );
endinterface

// File: rtl/gpio_rate_counter.sv
// Prescaled up/down modulo counter with load, clear, one-shot stop,
// terminal-count pulse and saturating wrap statistics.
module gpio_rate_counter #(
  parameter int WIDTH    = 20,
  parameter int MODULUS  = 1000000,
  parameter int PRESCALE = 1,
  parameter int WRAP_W   = 16
) (
  input  logic                clk,
  input  logic                reset,
  gpio_rate_counter_if.slave  bus
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [WIDTH-1:0] MAX_VAL  = WIDTH'(MODULUS - 1);
  localparam logic [PW-1:0]    PRE_LAST = PW'(PRESCALE - 1);

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_DONE = 1'b1
  } state_t;

  state_t            r_state, w_state_nxt;
  logic [WIDTH-1:0]  r_data, w_data_nxt;
  logic [PW-1:0]     r_presc, w_presc_nxt;
  logic              r_tc, w_tc_nxt;
  logic [WRAP_W-1:0] r_wrap, w_wrap_nxt;
  logic [WIDTH-1:0]  w_load_clamped;
  logic              w_terminal;

  // Load values above the top of the range are pinned to MODULUS-1.
  assign w_load_clamped = (bus.load_val > MAX_VAL) ? MAX_VAL : bus.load_val;
  assign w_terminal     = bus.dir ? (r_data == MAX_VAL) : (r_data == '0);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_RUN;
      r_data  <= '0;
      r_presc <= '0;
      r_tc    <= 1'b0;
      r_wrap  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_data  <= w_data_nxt;
      r_presc <= w_presc_nxt;
      r_tc    <= w_tc_nxt;
      r_wrap  <= w_wrap_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_data_nxt  = r_data;
    w_presc_nxt = r_presc;
    w_tc_nxt    = 1'b0;
    w_wrap_nxt  = r_wrap;
    if (bus.clr) begin
      w_state_nxt = ST_RUN;
      w_data_nxt  = '0;
      w_presc_nxt = '0;
      w_wrap_nxt  = '0;
    end else if (bus.load) begin
      w_state_nxt = ST_RUN;
      w_data_nxt  = w_load_clamped;
      w_presc_nxt = '0;
    end else if (bus.en && (r_state == ST_RUN)) begin
      if (r_presc == PRE_LAST) begin
        w_presc_nxt = '0;
        if (w_terminal) begin
          w_tc_nxt = 1'b1;
          if (!(&r_wrap)) begin
            w_wrap_nxt = r_wrap + WRAP_W'(1);
          end
          // One-shot parks on the terminal value; free-run wraps to the opposite end.
          if (bus.one_shot) begin
            w_state_nxt = ST_DONE;
          end else begin
            w_data_nxt = bus.dir ? '0 : MAX_VAL;
          end
        end else begin
          w_data_nxt = bus.dir ? (r_data + WIDTH'(1)) : (r_data - WIDTH'(1));
        end
      end else begin
        w_presc_nxt = r_presc + PW'(1);
      end
    end
  end

  assign bus.data      = r_data;
  assign bus.tc        = r_tc;
  assign bus.running   = (r_state == ST_RUN);
  assign bus.wrap_cnt  = r_wrap;
  assign bus.dbg_state = r_state;

endmodule
